pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and PC-sequencing controller for the 5-stage pipelined CPU (IF/ID/EXE/MEM/WB, branches and jumps resolved in ID). Each cycle it decides whether IF/ID advance, holds or flushes and whether ID/EXE receives a bubble. It also selects the next-PC source, drives operand forwarding for the ID-stage operand muxes, and keeps saturating stall/flush performance counters. It replaces the scattered stall logic in the control unit with one block.

## Interface
- CTRL_PENALTY, 1: bubbles inserted into IF/ID per taken branch or jump (legal range 1..3).
- CNT_W, 16: width of the performance counters.

- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous reset, active-low
- id_valid  in  1  ID holds a real (non-bubble) instruction
- id_rs, id_rt  in  5 each  ID source register numbers
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- id_is_branch  in  1  beq/bne in ID
- id_is_jump  in  1  j/jal in ID
- id_is_jr  in  1  jr in ID
- id_br_taken  in  1  branch condition from the forwarded ID compare
- exe_wreg, exe_m2reg  in  1 each  EXE instruction writes a register / is a load
- exe_rd  in  5  EXE destination register
- mem_wreg, mem_m2reg  in  1 each  MEM instruction writes a register / is a load
- mem_rd  in  5  MEM destination register
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load a nop into IF/ID (takes priority over ifid_we)
- idexe_bubble  out  1  load a nop into ID/EXE
- pcsource  out  2  00 = pc+4, 01 = bpc, 10 = jr rs, 11 = jpc
- fwda, fwdb  out  2 each  ID operand select: 00 = regfile, 01 = EXE ALU, 10 = MEM ALU, 11 = MEM load data
- stall  out  1  data-hazard stall this cycle
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters

## Operation
- A register hit needs all three: the stage writes a register (wreg=1), its rd≠0, and rd equals a source that ID uses.
- Forwarding for each operand (fwda from rs, fwdb from rt), priority EXE over MEM:
  - EXE hit and not a load → 01.
  - Otherwise MEM hit → 10, or 11 when mem_m2reg=1.
  - Otherwise 00.
- Data stall (stall=1) when id_valid=1 and any of the following holds:
  - (a) EXE hit with exe_m2reg=1 (load-use).
  - (b) the instruction is a branch or jr with an EXE hit (ID compare/target cannot use a same-cycle ALU result).
  - (c) the instruction is a branch or jr with a MEM hit and mem_m2reg=1.
- During a stall: pc_we=0, ifid_we=0, ifid_flush=0, idexe_bubble=1, pcsource=00.
  - Case (a) resolves after 1 cycle.
  - Branch on a load result: 2 stall cycles in total, cases (a)/(b) then (c).
- Redirect is evaluated only when there is no stall. It fires when id_valid=1 and one of:
  - a branch with id_br_taken=1 → pcsource=01;
  - jr → pcsource=10;
  - a jump → pcsource=11.
- In the redirect cycle: pc_we=1, ifid_flush=1, idexe_bubble=0. If CTRL_PENALTY>1, go to FLUSH with a down-counter loaded with CTRL_PENALTY−1.
- A not-taken branch does nothing extra: pcsource=00, normal advance.
- Normal cycle: pc_we=1, ifid_we=1, ifid_flush=0, idexe_bubble=0, pcsource=00.
- FSM has two states, RUN and FLUSH.
  - FLUSH outputs: pc_we=0, ifid_flush=1, idexe_bubble=0, stall=0, pcsource=00.
  - The counter decrements each FLUSH cycle; return to RUN on the cycle it reaches 0.
  - In FLUSH, ID inputs are ignored.
- Counters, each saturating at all-ones:
  - stall_cnt increments on every stall cycle.
  - flush_cnt increments on every cycle with ifid_flush=1.

## Timing
- Forwarding, stall and redirect outputs are combinational from the inputs and the FSM state. Only the state, the flush counter and the perf counters are registered.
- Resetn=0 (asynchronous, any time, including mid-FLUSH):
  - state=RUN, flush counter=0, stall_cnt=flush_cnt=0.
  - Outputs forced while Resetn=0: pc_we=0, ifid_we=0, ifid_flush=1, idexe_bubble=1, pcsource=00, fwda=fwdb=00, stall=0.
- First rising edge after Resetn rises: normal RUN behaviour.
- Simultaneous events:
  - A data stall masks a redirect in the same cycle; the redirect is re-evaluated once the stall clears.
  - A stall overrides a normal advance.
- A redirect never coincides with FLUSH, because ID holds a nop throughout FLUSH.

## Test plan
- **Reset:** hold Resetn=0 for 100 ns, then release → during reset all outputs take their forced values; first cycle after release gives pc_we=1, ifid_we=1, both counters 0.
- **Load-use:** exe_m2reg=1, exe_wreg=1, exe_rd=5; ID id_rs=5, id_use_rs=1 → stall=1, pc_we=0, idexe_bubble=1 for 1 cycle. Next cycle (load in MEM) → fwda=11, stall=0, stall_cnt=1.
- **Forward priority:** exe_rd=mem_rd=3, both wreg=1, no loads, id_rt=3, id_use_rt=1, add in ID → fwdb=01, no stall. Same with exe_rd=0 → fwdb=10.
- **Taken beq on a load result (CTRL_PENALTY=1):** stall=1 for 2 cycles. Then id_br_taken=1 → pcsource=01, pc_we=1, ifid_flush=1 for 1 cycle. Final counters: stall_cnt=2, flush_cnt=1.
- **Jump with CTRL_PENALTY=3:** redirect cycle pcsource=11, then 2 FLUSH cycles with pc_we=0, ifid_flush=1, then RUN. Assert Resetn=0 in the middle of the FLUSH cycles → state=RUN, counters cleared.
- **Saturation:** force 70000 stall cycles (CNT_W=16) → stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and PC-sequencing controller for the 5-stage pipeline.
// Handles stalls, redirects, ID operand forwarding and saturating perf counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CTRL_PENALTY = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_is_branch,
   input  logic             id_is_jump,
   input  logic             id_is_jr,
   input  logic             id_br_taken,
   input  logic             exe_wreg,
   input  logic             exe_m2reg,
   input  logic [4:0]       exe_rd,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic [4:0]       mem_rd,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idexe_bubble,
   output logic [1:0]       pcsource,
   output logic [1:0]       fwda,
   output logic [1:0]       fwdb,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [0:0] {StRun, StFlush} state_e;

   state_e     state_q;
   logic [1:0] flush_left_q;

   logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;
   logic exe_hit, mem_hit, br_or_jr;
   logic data_stall, redirect;
   logic [1:0] fwda_raw, fwdb_raw, redir_src;

   assign exe_hit_rs = exe_wreg && (exe_rd != 5'd0) && id_use_rs && (exe_rd == id_rs);
   assign exe_hit_rt = exe_wreg && (exe_rd != 5'd0) && id_use_rt && (exe_rd == id_rt);
   assign mem_hit_rs = mem_wreg && (mem_rd != 5'd0) && id_use_rs && (mem_rd == id_rs);
   assign mem_hit_rt = mem_wreg && (mem_rd != 5'd0) && id_use_rt && (mem_rd == id_rt);
   assign exe_hit    = exe_hit_rs || exe_hit_rt;
   assign mem_hit    = mem_hit_rs || mem_hit_rt;
   assign br_or_jr   = id_is_branch || id_is_jr;

   always_comb begin
      fwda_raw = 2'b00;
      if (exe_hit_rs && !exe_m2reg)  fwda_raw = 2'b01;
      else if (mem_hit_rs)           fwda_raw = mem_m2reg ? 2'b11 : 2'b10;
      fwdb_raw = 2'b00;
      if (exe_hit_rt && !exe_m2reg)  fwdb_raw = 2'b01;
      else if (mem_hit_rt)           fwdb_raw = mem_m2reg ? 2'b11 : 2'b10;
   end

   // ID-stage compare/target cannot see a same-cycle EXE result or MEM load data
   assign data_stall = id_valid && ((exe_hit && exe_m2reg) || (br_or_jr && exe_hit) ||
                                    (br_or_jr && mem_hit && mem_m2reg));

   always_comb begin
      redirect  = 1'b0;
      redir_src = 2'b00;
      if (id_valid) begin
         if (id_is_branch && id_br_taken) begin
            redirect  = 1'b1;
            redir_src = 2'b01;
         end else if (id_is_jr) begin
            redirect  = 1'b1;
            redir_src = 2'b10;
         end else if (id_is_jump) begin
            redirect  = 1'b1;
            redir_src = 2'b11;
         end
      end
   end

   always_comb begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      ifid_flush   = 1'b0;
      idexe_bubble = 1'b0;
      pcsource     = 2'b00;
      fwda         = fwda_raw;
      fwdb         = fwdb_raw;
      stall        = 1'b0;
      if (!Resetn) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         ifid_flush   = 1'b1;
         idexe_bubble = 1'b1;
         fwda         = 2'b00;
         fwdb         = 2'b00;
      end else if (state_q == StFlush) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         ifid_flush = 1'b1;
         fwda       = 2'b00;
         fwdb       = 2'b00;
      end else if (data_stall) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idexe_bubble = 1'b1;
         stall        = 1'b1;
      end else if (redirect) begin
         ifid_flush = 1'b1;
         pcsource   = redir_src;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q      <= StRun;
         flush_left_q <= 2'd0;
         stall_cnt    <= '0;
         flush_cnt    <= '0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (!data_stall && redirect && (CTRL_PENALTY > 1)) begin
                  state_q      <= StFlush;
                  flush_left_q <= 2'(CTRL_PENALTY - 1);
               end
            end
            StFlush: begin
               flush_left_q <= flush_left_q - 2'd1;
               if (flush_left_q <= 2'd1) state_q <= StRun;
            end
            default: state_q <= StRun;
         endcase
         if (stall && (stall_cnt != '1))      stall_cnt <= stall_cnt + 1'b1;
         if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
